// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch condition resolve with multi-cycle flush (optional BRANCH_STATS_EN counters)
module branch_resolve_unit #(
    parameter int PC_WIDTH     = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int FLAG_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  br_req,
    input  logic [2:0]            cond,
    input  logic [PC_WIDTH-1:0]   target,
    input  logic                  flag_we,
    input  logic [FLAG_WIDTH-1:0] flag_in,
    output logic [FLAG_WIDTH-1:0] flags,
    output logic                  pc_load,
    output logic [PC_WIDTH-1:0]   pc_target,
    output logic                  flush,
`ifdef BRANCH_STATS_EN
    output logic [15:0]           taken_cnt,
    output logic [15:0]           squash_cnt,
`endif
    output logic                  busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    logic [0:0]            state;
    logic [3:0]            cnt;
    logic [FLAG_WIDTH-1:0] eff_flags;
    logic                  s_f, z_f, c_f, v_f;
    logic                  cond_true;
    logic                  taken;

    // A flag write in the same cycle as the branch is forwarded so the branch sees the newest ALU result.
    always_comb begin
        eff_flags = (flag_we && br_req) ? flag_in : flags;
        s_f       = eff_flags[3];
        z_f       = eff_flags[2];
        c_f       = eff_flags[1];
        v_f       = eff_flags[0];
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = z_f;
            3'b001:  cond_true = s_f ^ v_f;
            3'b010:  cond_true = z_f | (s_f ^ v_f);
            3'b011:  cond_true = !z_f;
            3'b100:  cond_true = !(s_f ^ v_f);
            3'b101:  cond_true = !z_f & !(s_f ^ v_f);
            3'b110:  cond_true = c_f;
            default: cond_true = 1'b1;
        endcase
        taken = br_req && cond_true && (state == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags     <= '0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            flush     <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
            cnt       <= 4'd0;
        end else begin
            if (flag_we) begin
                flags <= flag_in;
            end
            pc_load <= taken;
            if (taken) begin
                pc_target <= target;
            end
            case (state)
                ST_IDLE: begin
                    if (taken) begin
                        state <= ST_FLUSH;
                        cnt   <= CNT_INIT;
                        flush <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    if (cnt == 4'd0) begin
                        state <= ST_IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Requests arriving while flushing are wrong-path and only counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt  <= 16'd0;
            squash_cnt <= 16'd0;
        end else begin
            if (taken && taken_cnt != 16'hFFFF) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
            if (br_req && state == ST_FLUSH && squash_cnt != 16'hFFFF) begin
                squash_cnt <= squash_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;

    localparam int FC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_req = 1'b0;
    logic [2:0]  cond = 3'd0;
    logic [15:0] target = 16'd0;
    logic        flag_we = 1'b0;
    logic [3:0]  flag_in = 4'd0;
    logic [3:0]  flags;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        flush;
    logic        busy;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] squash_cnt;
`endif

    branch_resolve_unit #(.PC_WIDTH(16), .FLUSH_CYCLES(FC), .FLAG_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .br_req    (br_req),
        .cond      (cond),
        .target    (target),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .flags     (flags),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .flush     (flush),
`ifdef BRANCH_STATS_EN
        .taken_cnt (taken_cnt),
        .squash_cnt(squash_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc_load;
        logic [15:0] pc_target;
        logic        flush;
        logic        busy;
        logic [3:0]  flags;
        logic [15:0] tcnt;
        logic [15:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: flush tracked as "cycles of flush remaining".
    logic [3:0]  m_flags = 4'd0;
    logic [15:0] m_target = 16'd0;
    int          m_left = 0;
    int          m_tcnt = 0;
    int          m_scnt = 0;

    function automatic logic cond_holds(input logic [2:0] c, input logic [3:0] f);
        logic s, z, cy, v, lt;
        s = f[3]; z = f[2]; cy = f[1]; v = f[0];
        lt = (s != v);
        case (c)
            3'd0: return z;
            3'd1: return lt;
            3'd2: return z || lt;
            3'd3: return !z;
            3'd4: return !lt;
            3'd5: return !z && !lt;
            3'd6: return cy;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input logic r, input logic req, input logic [2:0] c,
                         input logic [15:0] t, input logic we, input logic [3:0] fi);
        exp_t        e;
        logic [3:0]  eff;
        logic        tk;
        @(negedge clk);
        rst = r; br_req = req; cond = c; target = t; flag_we = we; flag_in = fi;
        eff = (we && req) ? fi : m_flags;
        tk  = req && cond_holds(c, eff) && (m_left == 0);
        if (r) begin
            m_flags = 4'd0; m_target = 16'd0; m_left = 0; m_tcnt = 0; m_scnt = 0;
            e.pc_load = 1'b0;
        end else begin
            if (req && m_left != 0 && m_scnt < 65535) m_scnt++;
            if (tk && m_tcnt < 65535) m_tcnt++;
            if (we) m_flags = fi;
            if (tk) begin
                m_target = t;
                m_left   = FC;
            end else if (m_left > 0) begin
                m_left--;
            end
            e.pc_load = tk;
        end
        e.pc_target = m_target;
        e.flush     = (m_left > 0);
        e.busy      = (m_left > 0);
        e.flags     = m_flags;
        e.tcnt      = 16'(m_tcnt);
        e.scnt      = 16'(m_scnt);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_load", {15'd0, pc_load}, {15'd0, e.pc_load});
                chk("flush", {15'd0, flush}, {15'd0, e.flush});
                chk("busy", {15'd0, busy}, {15'd0, e.busy});
                chk("flags", {12'd0, flags}, {12'd0, e.flags});
                chk("pc_target", pc_target, e.pc_target);
`ifdef BRANCH_STATS_EN
                chk("taken_cnt", taken_cnt, e.tcnt);
                chk("squash_cnt", squash_cnt, e.scnt);
`endif
            end
        end
    end

    initial begin : stimulus
        logic [3:0] sweep_flags [5];
        sweep_flags[0] = 4'b0000; sweep_flags[1] = 4'b0100; sweep_flags[2] = 4'b1000;
        sweep_flags[3] = 4'b1001; sweep_flags[4] = 4'b0010;

        drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
        idle(2);

        // EQ taken after a Z flag write
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 4'b0100);
        drive(1'b0, 1'b1, 3'd0, 16'h1234, 1'b0, 4'h0);
        idle(FC + 2);

        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < 8; c++) begin
                drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, sweep_flags[f]);
                drive(1'b0, 1'b1, 3'(c), 16'(16'h100 + f * 8 + c), 1'b0, 4'h0);
                idle(FC + 1);
            end
        end

        // Forwarding: same-cycle flag write decides the branch, then no write -> not taken
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 4'b0000);
        drive(1'b0, 1'b1, 3'd0, 16'h2222, 1'b1, 4'b0100);
        idle(FC + 1);
        drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 4'b0000);
        drive(1'b0, 1'b1, 3'd0, 16'h3333, 1'b0, 4'b0100);
        idle(2);

        // Squash during flush, flag write during flush still honoured
        drive(1'b0, 1'b1, 3'd7, 16'h1234, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 3'd7, 16'h0BAD, 1'b1, 4'b1010);
        idle(FC);
        drive(1'b0, 1'b1, 3'd7, 16'h4444, 1'b0, 4'h0);
        idle(FC + 1);

        // Reset in the 2nd flush cycle, then AL branch
        drive(1'b0, 1'b1, 3'd7, 16'h5555, 1'b0, 4'h0);
        idle(1);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 3'd7, 16'h6666, 1'b0, 4'h0);
        idle(FC + 1);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                  16'($urandom), ($urandom_range(0, 9) < 3), 4'($urandom));
        end
        idle(3);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
